mux8x1_ot: RTL and testbench

MUX8X1_OT -- requirements
Module: mux8x1_ot

---
 rtl/mux8x1_ot.sv | 76 +++++++
 tb/tb_mux8x1_ot.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux8x1_ot.sv
// mux8x1_ot: 8-to-1 multiplexer with a combinational output, a one-hot
// decode of the select, and an optionally captured (registered) copy of the
// output and select.
//
// Registered-path semantics: valid_q is a one-cycle marker, not a handshake.
// It is high exactly when Y_q/sel_q were loaded on the most recent rising
// clk edge (en sampled high), and low after any edge where en was low, or
// while/after rst. There is no ready input; the consumer must sample Y_q and
// sel_q whenever valid_q is high.
module mux8x1_ot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             S0,
    input  logic             S1,
    input  logic             S2,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    input  logic [WIDTH-1:0] I4,
    input  logic [WIDTH-1:0] I5,
    input  logic [WIDTH-1:0] I6,
    input  logic [WIDTH-1:0] I7,
    output logic [WIDTH-1:0] Y,
    output logic [7:0]       dec,
    output logic [WIDTH-1:0] Y_q,
    output logic [2:0]       sel_q,
    output logic             valid_q
);

    // Select index, S2 is the MSB.
    logic [2:0] sel;
    assign sel = {S2, S1, S0};

    // Data path: every code is decoded explicitly, no priority or fall-through.
    always_comb begin
        Y = '0;
        case (sel)
            3'd0: Y = I0;
            3'd1: Y = I1;
            3'd2: Y = I2;
            3'd3: Y = I3;
            3'd4: Y = I4;
            3'd5: Y = I5;
            3'd6: Y = I6;
            3'd7: Y = I7;
            default: Y = '0;
        endcase
    end

    // One-hot decode of the select, independent of clock and reset.
    always_comb begin
        dec = 8'b0000_0000;
        dec[sel] = 1'b1;
    end

    // Capture register: reset clears immediately; en gates the load and
    // valid_q follows en on every edge so it marks only fresh captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y_q     <= '0;
            sel_q   <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            valid_q <= en;
            if (en) begin
                Y_q   <= Y;
                sel_q <= sel;
            end
        end
    end

endmodule

// File: tb/tb_mux8x1_ot.sv
// Directed testbench for mux8x1_ot: walking-one decode, unselected-input
// isolation, registered capture/hold, async reset and release, and a
// WIDTH=4 instance.
module tb_mux8x1_ot;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] s;
    logic [2:0] s4;
    logic [0:0] din [8];
    logic [3:0] d4  [8];

    logic [0:0] y;
    logic [7:0] dec;
    logic [0:0] y_q;
    logic [2:0] sel_q;
    logic       valid_q;

    logic [3:0] y4;
    logic [7:0] dec4;
    logic [3:0] y4_q;
    logic [2:0] sel4_q;
    logic       valid4_q;

    int vectors;
    int miscompares;

    mux8x1_ot #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .en(en),
        .S0(s[0]), .S1(s[1]), .S2(s[2]),
        .I0(din[0]), .I1(din[1]), .I2(din[2]), .I3(din[3]),
        .I4(din[4]), .I5(din[5]), .I6(din[6]), .I7(din[7]),
        .Y(y), .dec(dec), .Y_q(y_q), .sel_q(sel_q), .valid_q(valid_q)
    );

    mux8x1_ot #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en),
        .S0(s4[0]), .S1(s4[1]), .S2(s4[2]),
        .I0(d4[0]), .I1(d4[1]), .I2(d4[2]), .I3(d4[3]),
        .I4(d4[4]), .I5(d4[5]), .I6(d4[6]), .I7(d4[7]),
        .Y(y4), .dec(dec4), .Y_q(y4_q), .sel_q(sel4_q), .valid_q(valid4_q)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        en  = 1'b0;
        s   = 3'd0;
        s4  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            din[i] = 1'b0;
            d4[i]  = 4'h0;
        end

        // Reset assertion between edges clears registers at once.
        #2 rst = 1'b1;
        #1;
        chk("reset_y_q", 32'(y_q), 32'h0);
        chk("reset_sel_q", 32'(sel_q), 32'h0);
        chk("reset_valid_q", 32'(valid_q), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Walking one across all eight select codes.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) din[i] = 1'b0;
            din[k] = 1'b1;
            s = 3'(k);
            #10;
            chk($sformatf("walk_y_%0d", k), 32'(y), 32'h1);
            chk($sformatf("walk_dec_%0d", k), 32'(dec), 32'h1 << k);
        end

        // Unselected inputs must not reach Y; selected input toggles through.
        @(negedge clk);
        s = 3'b101;
        for (int i = 0; i < 8; i++) din[i] = 1'b1;
        din[5] = 1'b0;
        #1 chk("iso_y_low", 32'(y), 32'h0);
        chk("iso_dec", 32'(dec), 32'h20);
        din[5] = 1'b1;
        #1 chk("iso_y_high", 32'(y), 32'h1);

        // Enabled capture.
        @(negedge clk);
        en = 1'b1;
        s  = 3'b011;
        for (int i = 0; i < 8; i++) din[i] = 1'b0;
        din[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("cap_y_q", 32'(y_q), 32'h1);
        chk("cap_sel_q", 32'(sel_q), 32'h3);
        chk("cap_valid_q", 32'(valid_q), 32'h1);

        // Disabled edge holds data, drops valid.
        @(negedge clk);
        en = 1'b0;
        s  = 3'b000;
        din[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_y_q", 32'(y_q), 32'h1);
        chk("hold_sel_q", 32'(sel_q), 32'h3);
        chk("hold_valid_q", 32'(valid_q), 32'h0);
        chk("hold_y", 32'(y), 32'h0);

        // Recapture so valid_q is high before reset.
        @(negedge clk);
        en = 1'b1;
        s  = 3'b011;
        @(posedge clk);
        #1;
        chk("recap_valid_q", 32'(valid_q), 32'h1);
        chk("recap_y_q", 32'(y_q), 32'h1);

        // Async reset between edges.
        #1 rst = 1'b1;
        #1;
        chk("arst_y_q", 32'(y_q), 32'h0);
        chk("arst_sel_q", 32'(sel_q), 32'h0);
        chk("arst_valid_q", 32'(valid_q), 32'h0);
        chk("arst_y", 32'(y), 32'h1);
        chk("arst_dec", 32'(dec), 32'h08);

        // Clock edge with en=1 while held in reset.
        @(posedge clk);
        #1;
        chk("inrst_y_q", 32'(y_q), 32'h0);
        chk("inrst_valid_q", 32'(valid_q), 32'h0);

        // Release: nothing captured until the first enabled edge.
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        s   = 3'b111;
        din[7] = 1'b1;
        #1;
        chk("rel_pre_y_q", 32'(y_q), 32'h0);
        chk("rel_pre_y", 32'(y), 32'h1);
        @(posedge clk);
        #1;
        chk("rel_y_q", 32'(y_q), 32'h1);
        chk("rel_sel_q", 32'(sel_q), 32'h7);
        chk("rel_valid_q", 32'(valid_q), 32'h1);

        // Mid-cycle input changes do not touch registers.
        #1;
        s = 3'b000;
        din[0] = 1'b0;
        #1;
        chk("mid_y", 32'(y), 32'h0);
        chk("mid_y_q", 32'(y_q), 32'h1);
        chk("mid_sel_q", 32'(sel_q), 32'h7);

        // WIDTH=4: selected input 4'hA, all others 4'h5.
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 8; i++) d4[i] = 4'h5;
            d4[k] = 4'hA;
            s4 = 3'(k);
            #1;
            chk($sformatf("w4_y_%0d", k), 32'(y4), 32'hA);
        end
        @(posedge clk);
        #1;
        chk("w4_y_q", 32'(y4_q), 32'hA);
        chk("w4_sel_q", 32'(sel4_q), 32'h7);
        chk("w4_dec", 32'(dec4), 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
